booth_controller: RTL and testbench
===================================

// Module: booth_controller
// PURPOSE
//  Control FSM for the radix-2 Booth multiplier. Sequences the A and Q
//  arithmetic-right shift registers, the Q[-1] flip-flop, the M register and
//  the add/sub ALU through N Booth iterations.
//  It consumes q0 (Q[0]) and qm1 (Q[-1]) from the datapath.
//  It issues the load/clear/shift strobes the shift registers take, and flags completion.
// PARAMETERS
//  N   8                  operand width = number of Booth iterations
//  CW  $clog2(N+1)        iteration counter width (derived, do not override)
// PORTS
//  clk     in   1  single clock, all state updates on posedge
//  clear   in   1  synchronous, active-high reset; dominates every other input
//  start   in   1  begin a multiply; honoured only in IDLE or DONE
//  q0      in   1  Q[0] from Q shift register
//  qm1     in   1  Q[-1] flip-flop value
//  ld_m    out  1  load multiplicand register
//  ld_q    out  1  load Q register (multiplier)
//  clr_a   out  1  clear accumulator A
//  clr_ff  out  1  clear Q[-1] flip-flop
//  ld_a    out  1  load A with ALU result
//  addsub  out  1  ALU op: 0 = A+M, 1 = A-M (only meaningful while ld_a=1)
//  sft_a   out  1  arithmetic right shift A
//  sft_q   out  1  right shift Q (serial_in = A[0])
//  sft_ff  out  1  load Q[-1] <= Q[0]
//  busy    out  1  high in LOAD/CHECK/ADD/SUB/SHIFT
//  done    out  1  high while in DONE
// BEHAVIOUR
//  - Clock and reset: one clock, clk; clear is the reset, synchronous and active-high.
//  - clear: next edge -> IDLE, count=0. All outputs are 0 in IDLE.
//  - Moore outputs: every strobe is decoded from the current state. The datapath captures at the end of that cycle.
//  - States (3-bit): IDLE, LOAD, CHECK, ADD, SUB, SHIFT, DONE.
//  - IDLE: start=1 -> LOAD, else stay.
//  - LOAD: ld_m=ld_q=clr_a=clr_ff=1; count <= N; -> CHECK.
//  - CHECK: no strobes. q0/qm1 are sampled only here.
//      {q0,qm1}=10 -> SUB; 01 -> ADD; 00 or 11 -> SHIFT.
//  - ADD: ld_a=1, addsub=0; -> SHIFT.
//  - SUB: ld_a=1, addsub=1; -> SHIFT.
//  - SHIFT: sft_a=sft_q=sft_ff=1; count <= count-1.
//      If count==1 (pre-decrement) -> DONE, else -> CHECK.
//  - DONE: done=1, busy=0. start=1 -> LOAD (done drops that cycle), else hold.
//  - Latency from LOAD entry to DONE entry: 2N+1 to 3N+1 cycles (2 or 3 per iteration).
//  - start in LOAD/CHECK/ADD/SUB/SHIFT is ignored.
//  - clear+start in the same cycle: clear wins.
//  - Invariants: ld_a and sft_a never both high. ld_a and clr_a never both high.
//    At most one state-group of strobes is active per cycle.
//  - Wrap: count never underflows; it is 0 outside an operation. N=1 is legal.
// CONFIGURATION
//  - Macro BOOTH_ABORT_EN adds input port abort (1 bit).
//    abort=1 in any busy state -> IDLE next edge; done is not asserted.
//    Counter is zeroed. abort is ignored in IDLE/DONE. clear has priority over abort.
//  - Without BOOTH_ABORT_EN: no abort port, and an operation always runs to DONE.
// STRUCTURE
//  - booth_pkg: state encodings, OP_ADD=1'b0 / OP_SUB=1'b1, Booth pair codes (2'b10, 2'b01).
//  - One sub-module, booth_counter (CW-bit down-counter): load, decr, last (count==1).
//  - The FSM and output decode stay in booth_controller.
// TESTING
//  1. Reset: hold clear 2 cycles with start=1 -> state IDLE, every output 0, busy=0.
//  2. N=8, q0=qm1=0 held: start pulse -> LOAD strobes for exactly 1 cycle, then 8 CHECK/SHIFT pairs.
//     No ld_a pulse; done rises 17 cycles after LOAD entry.
//  3. {q0,qm1}=10 at first CHECK -> SUB cycle with ld_a=1, addsub=1, then SHIFT.
//     {q0,qm1}=01 next -> ADD with addsub=0.
//  4. Closed loop with shiftreg/ALU models: M=3, Q=8'hFB (-5) -> {A,Q}=16'hFFF1 (-15) at done.
//     Also M=8'h80, Q=8'h80 -> 16'h4000.
//  5. clear asserted during SUB -> next cycle IDLE, all strobes 0, done=0.
//     A following start completes normally.
//  6. start pulsed mid-operation -> ignored, same cycle count.
//     start in DONE -> LOAD next edge, done=0.
//     With BOOTH_ABORT_EN: abort in SHIFT -> IDLE, no done pulse.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the radix-2 Booth multiplier controller.
//   state_e      - FSM state encoding (3-bit)
//   OP_ADD/SUB   - ALU operation select values driven on addsub
//   PAIR_SUB/ADD - {Q[0],Q[-1]} codes that call for a subtract / add
//   strobes_t    - bundle of every controller output strobe
//   decode_state - Moore decode of a state into its strobes
package booth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ADD   = 3'd3,
        ST_SUB   = 3'd4,
        ST_SHIFT = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] PAIR_SUB = 2'b10;
    localparam logic [1:0] PAIR_ADD = 2'b01;

    typedef struct packed {
        logic ld_m;
        logic ld_q;
        logic clr_a;
        logic clr_ff;
        logic ld_a;
        logic addsub;
        logic sft_a;
        logic sft_q;
        logic sft_ff;
        logic busy;
        logic done;
    } strobes_t;

    function automatic strobes_t decode_state(input state_e st);
        strobes_t s;
        s = '0;
        case (st)
            ST_LOAD: begin
                s.ld_m   = 1'b1;
                s.ld_q   = 1'b1;
                s.clr_a  = 1'b1;
                s.clr_ff = 1'b1;
                s.busy   = 1'b1;
            end
            ST_CHECK: begin
                s.busy = 1'b1;
            end
            ST_ADD: begin
                s.ld_a   = 1'b1;
                s.addsub = OP_ADD;
                s.busy   = 1'b1;
            end
            ST_SUB: begin
                s.ld_a   = 1'b1;
                s.addsub = OP_SUB;
                s.busy   = 1'b1;
            end
            ST_SHIFT: begin
                s.sft_a  = 1'b1;
                s.sft_q  = 1'b1;
                s.sft_ff = 1'b1;
                s.busy   = 1'b1;
            end
            ST_DONE: begin
                s.done = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_counter.sv
// booth_counter: iteration down-counter for the Booth controller.
//   clk   - clock
//   clear - synchronous zero (dominates load/decr)
//   load  - count <= N
//   decr  - count <= count-1 (holds at 0, never wraps)
//   last  - count == 1
module booth_counter #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic decr,
    output logic last
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = CW'(N);
        end else if (decr && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == CW'(1));

endmodule

// File: rtl/booth_controller.sv
// booth_controller: control FSM for a radix-2 Booth multiplier.
// Sequences LOAD, then N iterations of CHECK -> (ADD|SUB) -> SHIFT, then DONE.
//   clk, clear      - clock and synchronous active-high reset
//   start           - begin a multiply (honoured in IDLE/DONE only)
//   q0, qm1         - Q[0] and Q[-1] from the datapath, sampled in CHECK
//   abort           - present only when BOOTH_ABORT_EN is defined; returns a
//                     busy controller to IDLE without asserting done
//   ld_m..sft_ff    - datapath strobes, Moore-decoded from the state
//   busy, done      - status
// Optional feature macro: BOOTH_ABORT_EN.
module booth_controller
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic q0,
    input  logic qm1,
`ifdef BOOTH_ABORT_EN
    input  logic abort,
`endif
    output logic ld_m,
    output logic ld_q,
    output logic clr_a,
    output logic clr_ff,
    output logic ld_a,
    output logic addsub,
    output logic sft_a,
    output logic sft_q,
    output logic sft_ff,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = $clog2(N + 1);

    state_e   state_q, state_d;
    strobes_t strb_q, strb_d;
    logic     abort_hit;
    logic     cnt_clear;
    logic     cnt_last;

    always_comb begin
        abort_hit = 1'b0;
`ifdef BOOTH_ABORT_EN
        abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif
    end

    always_comb begin
        state_d = state_q;
        if (clear || abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_CHECK;
                ST_CHECK: begin
                    case ({q0, qm1})
                        PAIR_SUB: state_d = ST_SUB;
                        PAIR_ADD: state_d = ST_ADD;
                        default:  state_d = ST_SHIFT;
                    endcase
                end
                ST_ADD:   state_d = ST_SHIFT;
                ST_SUB:   state_d = ST_SHIFT;
                ST_SHIFT: state_d = cnt_last ? ST_DONE : ST_CHECK;
                ST_DONE:  if (start) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;
            endcase
        end
        // Outputs are registered alongside the state, so decoding the next
        // state keeps them Moore outputs of the current state.
        strb_d = decode_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
        end
    end

    assign cnt_clear = clear || abort_hit;

    booth_counter #(
        .N  (N),
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .clear (cnt_clear),
        .load  (state_q == ST_LOAD),
        .decr  (state_q == ST_SHIFT),
        .last  (cnt_last)
    );

    assign ld_m   = strb_q.ld_m;
    assign ld_q   = strb_q.ld_q;
    assign clr_a  = strb_q.clr_a;
    assign clr_ff = strb_q.clr_ff;
    assign ld_a   = strb_q.ld_a;
    assign addsub = strb_q.addsub;
    assign sft_a  = strb_q.sft_a;
    assign sft_q  = strb_q.sft_q;
    assign sft_ff = strb_q.sft_ff;
    assign busy   = strb_q.busy;
    assign done   = strb_q.done;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: directed self-checking bench for booth_controller (N=8).
// Includes a behavioural shift-register/ALU datapath for closed-loop products.
module tb_booth_controller;

    // Output vector order: ld_m ld_q clr_a clr_ff ld_a addsub sft_a sft_q sft_ff busy done
    localparam logic [10:0] P_IDLE  = 11'b00000000000;
    localparam logic [10:0] P_LOAD  = 11'b11110000010;
    localparam logic [10:0] P_CHECK = 11'b00000000010;
    localparam logic [10:0] P_ADD   = 11'b00001000010;
    localparam logic [10:0] P_SUB   = 11'b00001100010;
    localparam logic [10:0] P_SHIFT = 11'b00000011110;
    localparam logic [10:0] P_DONE  = 11'b00000000001;

    logic clk = 1'b0;
    logic clear, start, q0, qm1, q0_man, qm1_man, use_model;
    logic ld_m, ld_q, clr_a, clr_ff, ld_a, addsub, sft_a, sft_q, sft_ff, busy, done;
`ifdef BOOTH_ABORT_EN
    logic abort;
`endif
    logic [10:0] outs;

    // A carries a guard bit so that subtracting M = -2^(N-1) cannot overflow.
    logic [8:0] dp_a, dp_m;
    logic [7:0] dp_q;
    logic       dp_qm1;
    logic [7:0] m_in, q_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_controller #(.N(8)) dut (
        .clk    (clk),
        .clear  (clear),
        .start  (start),
        .q0     (q0),
        .qm1    (qm1),
`ifdef BOOTH_ABORT_EN
        .abort  (abort),
`endif
        .ld_m   (ld_m),
        .ld_q   (ld_q),
        .clr_a  (clr_a),
        .clr_ff (clr_ff),
        .ld_a   (ld_a),
        .addsub (addsub),
        .sft_a  (sft_a),
        .sft_q  (sft_q),
        .sft_ff (sft_ff),
        .busy   (busy),
        .done   (done)
    );

    assign outs = {ld_m, ld_q, clr_a, clr_ff, ld_a, addsub, sft_a, sft_q, sft_ff, busy, done};
    assign q0   = use_model ? dp_q[0] : q0_man;
    assign qm1  = use_model ? dp_qm1  : qm1_man;

    always_ff @(posedge clk) begin
        if (ld_m)   dp_m   <= {m_in[7], m_in};
        if (ld_q)   dp_q   <= q_in;
        if (clr_a)  dp_a   <= '0;
        if (clr_ff) dp_qm1 <= 1'b0;
        if (ld_a)   dp_a   <= addsub ? (dp_a - dp_m) : (dp_a + dp_m);
        if (sft_a)  dp_a   <= {dp_a[8], dp_a[8:1]};
        if (sft_q)  dp_q   <= {dp_a[0], dp_q[7:1]};
        if (sft_ff) dp_qm1 <= dp_q[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-loop multiply; mid_start >= 0 pulses start at that cycle index.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int exp_cyc,
                          input logic [15:0] exp_prod, input int mid_start);
        int cyc;
        m_in = m;
        q_in = q;
        use_model = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("op_load", 32'(outs), 32'(P_LOAD));
        cyc = 0;
        while (!done && cyc < 100) begin
            start = (cyc == mid_start);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("op_cycles", 32'(cyc), 32'(exp_cyc));
        check("op_product", 32'({dp_a[7:0], dp_q}), 32'(exp_prod));
        check("op_done", 32'(outs), 32'(P_DONE));
    endtask

    initial begin
        clear = 1'b1; start = 1'b1; q0_man = 1'b0; qm1_man = 1'b0; use_model = 1'b0;
        m_in = '0; q_in = '0;
`ifdef BOOTH_ABORT_EN
        abort = 1'b0;
`endif
        // Reset with start held high: clear wins
        tick();
        check("reset_c1", 32'(outs), 32'(P_IDLE));
        tick();
        check("reset_c2", 32'(outs), 32'(P_IDLE));
        clear = 1'b0; start = 1'b0;
        tick();
        check("idle_hold", 32'(outs), 32'(P_IDLE));

        // All-zero multiplier bits: LOAD then 8 CHECK/SHIFT pairs, done 17 cycles after LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        check("z_load", 32'(outs), 32'(P_LOAD));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("z_check", 32'(outs), 32'(P_CHECK));
            tick();
            check("z_shift", 32'(outs), 32'(P_SHIFT));
        end
        tick();
        check("z_done", 32'(outs), 32'(P_DONE));
        tick();
        check("z_done_hold", 32'(outs), 32'(P_DONE));

        // start in DONE -> LOAD; then SUB for 10 and ADD for 01
        start = 1'b1;
        tick();
        start = 1'b0;
        check("d_restart", 32'(outs), 32'(P_LOAD));
        tick();
        check("s_check", 32'(outs), 32'(P_CHECK));
        q0_man = 1'b1; qm1_man = 1'b0;
        tick();
        check("s_sub", 32'(outs), 32'(P_SUB));
        q0_man = 1'b0; qm1_man = 1'b1;
        tick();
        check("s_shift", 32'(outs), 32'(P_SHIFT));
        tick();
        check("a_check", 32'(outs), 32'(P_CHECK));
        tick();
        check("a_add", 32'(outs), 32'(P_ADD));
        q0_man = 1'b0; qm1_man = 1'b0;
        tick();
        check("a_shift", 32'(outs), 32'(P_SHIFT));
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
        end
        tick();
        check("a_done", 32'(outs), 32'(P_DONE));

        // clear during SUB
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        q0_man = 1'b1; qm1_man = 1'b0;
        tick();
        check("c_sub", 32'(outs), 32'(P_SUB));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("c_idle", 32'(outs), 32'(P_IDLE));
        tick();
        check("c_idle_hold", 32'(outs), 32'(P_IDLE));

        // Closed loop: 3 * -5 = -15 (three add/sub iterations -> 17+3 cycles)
        run_op(8'h03, 8'hFB, 20, 16'hFFF1, -1);
        // -128 * -128 = 16384 (one subtract iteration)
        run_op(8'h80, 8'h80, 18, 16'h4000, -1);
        // start pulsed mid-operation is ignored
        run_op(8'h03, 8'hFB, 20, 16'hFFF1, 5);

        // start in DONE -> LOAD on the next edge, done drops
        use_model = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_to_load", 32'(outs), 32'(P_LOAD));

`ifdef BOOTH_ABORT_EN
        q0_man = 1'b0; qm1_man = 1'b0;
        tick();
        tick();
        check("ab_shift", 32'(outs), 32'(P_SHIFT));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle", 32'(outs), 32'(P_IDLE));
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ab_no_done", 32'(outs), 32'(P_IDLE));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
